// File: rtl/dram_refresh_arbiter.sv
// dram_refresh_arbiter: shares the fast-RAM array between CPU cycles and CBR refresh with deferred, debt-bounded refresh
module dram_refresh_arbiter #(
  parameter int REFRESH_INTERVAL = 156,
  parameter int MAX_DEBT         = 4,
  parameter int RAS_HOLD         = 2
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       CPU_REQ,
  output logic       CPU_GNT,
  output logic       REF_RAS,
  output logic       REF_CAS,
  output logic       REF_ACTIVE,
  output logic [2:0] DEBT,
  output logic       OVERRUN
);
  typedef enum logic [2:0] {IDLE, CPU, PRECHARGE, CBR_CAS, CBR_RAS, CBR_REL} state_t;
  localparam logic [11:0] LAST      = 12'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]  MAXD      = 3'(MAX_DEBT);
  localparam logic [1:0]  HOLD_LAST = 2'(RAS_HOLD - 1);
  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  hold_q, hold_d;
  logic [2:0]  debt_q, debt_d;
  logic        gnt_q, gnt_d, ras_q, ras_d, cas_q, cas_d, act_q, act_d, ovr_q, ovr_d;
  logic        tick, done;
  assign tick = cnt_q == LAST;
  assign done = state_q == CBR_REL;
  // interval timer and refresh debt; a tick coinciding with a completion cancels out
  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 12'd1;
    debt_d = debt_q;
    ovr_d  = ovr_q;
    if (tick && !done) begin
      if (debt_q == MAXD) ovr_d = 1'b1;
      else debt_d = debt_q + 3'd1;
    end else if (done && !tick) begin
      debt_d = debt_q - 3'd1;
    end
  end
  // arbitration FSM; strobe and grant values are computed for the state being entered
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    ras_d   = ras_q;
    cas_d   = cas_q;
    act_d   = act_q;
    case (state_q)
      IDLE: begin
        if (debt_q == MAXD || (!CPU_REQ && debt_q != 3'd0)) begin
          state_d = CBR_CAS;
          cas_d   = 1'b0;
          act_d   = 1'b1;
        end else if (CPU_REQ) begin
          state_d = CPU;
          gnt_d   = 1'b1;
        end
      end
      CPU: begin
        if (!CPU_REQ) begin
          state_d = PRECHARGE;
          gnt_d   = 1'b0;
        end
      end
      PRECHARGE: state_d = IDLE;
      CBR_CAS: begin
        state_d = CBR_RAS;
        ras_d   = 1'b0;
        hold_d  = '0;
      end
      CBR_RAS: begin
        if (hold_q == HOLD_LAST) begin
          state_d = CBR_REL;
          ras_d   = 1'b1;
          cas_d   = 1'b1;
        end else begin
          hold_d = hold_q + 2'd1;
        end
      end
      CBR_REL: begin
        state_d = PRECHARGE;
        act_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset releases the strobes without waiting for a clock
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      debt_q  <= '0;
      gnt_q   <= 1'b0;
      ras_q   <= 1'b1;
      cas_q   <= 1'b1;
      act_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      debt_q  <= debt_d;
      gnt_q   <= gnt_d;
      ras_q   <= ras_d;
      cas_q   <= cas_d;
      act_q   <= act_d;
      ovr_q   <= ovr_d;
    end
  end
  assign CPU_GNT    = gnt_q;
  assign REF_RAS    = ras_q;
  assign REF_CAS    = cas_q;
  assign REF_ACTIVE = act_q;
  assign DEBT       = debt_q;
  assign OVERRUN    = ovr_q;
endmodule
